// File: rtl/alu_seq_unit.sv
// alu_seq_unit -- multi-cycle ALU for the CPU execute stage.
//
// Operations: add, sub, mul, div, mod, and, or, xor (opcodes 0..7). Opcodes 8..15
// return 0 with only the zero flag set. Mul, div and mod are computed iteratively.
// Division by zero gives all ones (div) or the dividend (mod), with overflow = 1.
// Results and flags are registered and held until the consumer accepts them.
//
// Build option: `define ALU_MUL_ITER_EN to compute mul with the WIDTH-cycle shift-add
// path. Leave it undefined for a single-cycle combinational multiply; the result and
// flags are the same in both builds. Div and mod are iterative in both builds.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   a, b         operands (WIDTH bits)
//   operacion    4-bit opcode
//   in_valid     operands/opcode valid     in_ready   unit can accept (IDLE only)
//   resultado    registered result         flagsResult {sign, zero, carry, overflow}
//   out_valid    result valid              out_ready  consumer accepts the result
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       operacion,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] resultado,
    output logic [3:0]       flagsResult,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;

`ifdef ALU_MUL_ITER_EN
    localparam logic MUL_ITER = 1'b1;
`else
    localparam logic MUL_ITER = 1'b0;
`endif

    // S_LOAD is the cycle after acceptance: operands are already in r_a/r_b/r_op and the
    // unit either writes a single-cycle result or starts iterating from there.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_resultado;
    logic [3:0]       r_flags;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_rsh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quot_nxt;
    logic             w_iter;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_cry;
    logic [3:0]       w_flags;

`ifdef ALU_MUL_ITER_EN
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_prod_nxt;
`else
    logic [2*WIDTH-1:0] w_prod;
`endif

    // Pack {sign, zero, carry, overflow} from a result and its arithmetic flags.
    function automatic logic [3:0] f_flags(input logic [WIDTH-1:0] res,
                                           input logic ovf, input logic cry);
        return {res[WIDTH-1], (res == {WIDTH{1'b0}}), cry, ovf};
    endfunction

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // One restoring-division step: shift the next dividend bit into the remainder.
    // When w_ge holds the true difference is below 2^WIDTH, so a WIDTH-bit subtract
    // of the low bits is exact. With b = 0 every step subtracts nothing, which
    // naturally yields an all-ones quotient and a remainder equal to a.
    assign w_rsh      = {r_rem, r_quot[WIDTH-1]};
    assign w_ge       = (w_rsh >= {1'b0, r_b});
    assign w_rem_nxt  = w_ge ? (w_rsh[WIDTH-1:0] - r_b) : w_rsh[WIDTH-1:0];
    assign w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};

`ifdef ALU_MUL_ITER_EN
    // One shift-add multiply step driven by the low multiplier bit.
    assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
`else
    assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
`endif

    assign w_iter = (r_op == OP_DIV) || (r_op == OP_MOD) || (MUL_ITER && (r_op == OP_MUL));

    // Final result and arithmetic flags for the value written on DONE entry.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_ovf = 1'b0;
        w_cry = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cry = w_sum[WIDTH];
                w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_cry = ~w_diff[WIDTH];
                w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_MUL: begin
`ifdef ALU_MUL_ITER_EN
                w_res = w_prod_nxt[WIDTH-1:0];
                w_ovf = |w_prod_nxt[2*WIDTH-1:WIDTH];
`else
                w_res = w_prod[WIDTH-1:0];
                w_ovf = |w_prod[2*WIDTH-1:WIDTH];
`endif
            end
            OP_DIV: begin
                w_res = w_quot_nxt;
                w_ovf = (r_b == {WIDTH{1'b0}});
            end
            OP_MOD: begin
                w_res = w_rem_nxt;
                w_ovf = (r_b == {WIDTH{1'b0}});
            end
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            default: w_res = {WIDTH{1'b0}};
        endcase
    end

    assign w_flags = f_flags(w_res, w_ovf, w_cry);

    // Control FSM, operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_resultado <= {WIDTH{1'b0}};
            r_flags     <= 4'b0000;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_op        <= 4'd0;
            r_cnt       <= {CW{1'b0}};
            r_rem       <= {WIDTH{1'b0}};
            r_quot      <= {WIDTH{1'b0}};
`ifdef ALU_MUL_ITER_EN
            r_prod      <= {(2*WIDTH){1'b0}};
            r_mcand     <= {(2*WIDTH){1'b0}};
            r_mplier    <= {WIDTH{1'b0}};
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= operacion;
                        r_rem      <= {WIDTH{1'b0}};
                        r_quot     <= a;
`ifdef ALU_MUL_ITER_EN
                        r_prod     <= {(2*WIDTH){1'b0}};
                        r_mcand    <= {{WIDTH{1'b0}}, a};
                        r_mplier   <= b;
`endif
                        r_in_ready <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_iter) begin
                        r_cnt   <= CW'(WIDTH);
                        r_state <= S_CALC;
                    end else begin
                        r_resultado <= w_res;
                        r_flags     <= w_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_CALC: begin
                    r_cnt  <= r_cnt - CW'(1);
                    r_rem  <= w_rem_nxt;
                    r_quot <= w_quot_nxt;
`ifdef ALU_MUL_ITER_EN
                    r_prod   <= w_prod_nxt;
                    r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
`endif
                    // Last iteration: w_res already reflects this step's outcome.
                    if (r_cnt == CW'(1)) begin
                        r_resultado <= w_res;
                        r_flags     <= w_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign resultado   = r_resultado;
    assign flagsResult = r_flags;

endmodule
